// File: rtl/gs_prescaler.sv
// rtl/gs_prescaler.sv - operand conditioning and reciprocal seed for the Goldschmidt divider
module gs_prescaler #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_mag,
  output logic [WIDTH-1:0] b_norm,
  output logic [SHW-1:0]   nshift,
  output logic             q_sign,
  output logic [WIDTH-1:0] x0,
  output logic             div0
);

  // The seed table is indexed by the three bits below the leading one, so it only fits 8 bits.
  generate
    if (WIDTH != 8 || SHW != 3) begin : g_bad_width
      $error("gs_prescaler supports only WIDTH=8, SHW=3");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state;

  // Two's-complement magnitude; the most negative value wraps to itself (0x80 reads as 128).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
  endfunction

  // Reciprocal seed in Q1.7 for the centre of each 1/16-wide slice of [0.5,1).
  function automatic logic [WIDTH-1:0] seed(input logic [2:0] idx);
    logic [WIDTH-1:0] r;
    case (idx)
      3'd0:    r = 8'd241;
      3'd1:    r = 8'd216;
      3'd2:    r = 8'd195;
      3'd3:    r = 8'd178;
      3'd4:    r = 8'd164;
      3'd5:    r = 8'd152;
      3'd6:    r = 8'd141;
      default: r = 8'd132;
    endcase
    return r;
  endfunction

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Control FSM and result registers; b_norm doubles as the working shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_mag  <= '0;
      b_norm <= '0;
      nshift <= '0;
      q_sign <= 1'b0;
      x0     <= '0;
      div0   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_mag  <= magnitude(a_in);
            b_norm <= magnitude(b_in);
            nshift <= '0;
            q_sign <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            x0     <= '0;
            div0   <= (b_in == '0);
            state  <= S_NORM;
          end
        end
        S_NORM: begin
          if (b_norm == '0) begin
            // Divide by zero: leave b_norm and x0 at zero, report after a single cycle.
            state <= S_DONE;
          end else if (b_norm[WIDTH-1]) begin
            x0    <= seed(b_norm[WIDTH-2 -: 3]);
            state <= S_DONE;
          end else begin
            b_norm <= b_norm << 1;
            nshift <= nshift + SHW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gs_prescaler.sv
// tb/tb_gs_prescaler.sv - randomized self-checking bench for gs_prescaler
module tb_gs_prescaler;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] a_mag;
  logic [7:0] b_norm;
  logic [2:0] nshift;
  logic       q_sign;
  logic [7:0] x0;
  logic       div0;

  int total = 0;
  int bad   = 0;

  gs_prescaler dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_mag     (a_mag),
    .b_norm    (b_norm),
    .nshift    (nshift),
    .q_sign    (q_sign),
    .x0        (x0),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operand values.
  // Result packing: {a_mag, b_norm, nshift, q_sign, x0, div0} = 29 bits.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [28:0] res, output int lat);
    int lut [8] = '{241, 216, 195, 178, 164, 152, 141, 132};
    int av, bv, am, bm, sh, sd;
    av = $signed(a);
    bv = $signed(b);
    am = (av < 0) ? -av : av;
    bm = (bv < 0) ? -bv : bv;
    sh = 0;
    sd = 0;
    if (bm != 0) begin
      while (bm < 128) begin
        bm = bm * 2;
        sh = sh + 1;
      end
      sd = lut[(bm / 16) % 8];
    end
    lat = 1 + sh;
    res = {am[7:0], bm[7:0], sh[2:0], a[7] ^ b[7], sd[7:0], (bv == 0)};
  endfunction

  function automatic logic [28:0] observed();
    return {a_mag, b_norm, nshift, q_sign, x0, div0};
  endfunction

  // One full operation starting at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold, input string tag);
    logic [28:0] exp_res;
    int exp_lat;
    int cnt;
    model(a, b, exp_res, exp_lat);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s accept_ready: got %b want 1", tag, in_ready);
    end
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_in = 8'($urandom);
    b_in = 8'($urandom);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s busy_ready: got %b want 0", tag, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    total++;
    if (cnt !== exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d (a=%h b=%h)", tag, cnt, exp_lat, a, b);
    end
    total++;
    if (observed() !== exp_res) begin
      bad++;
      $display("FAIL %s result: got %h want %h (a=%h b=%h)", tag, observed(), exp_res, a, b);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, observed()} !== {1'b1, 1'b0, exp_res}) begin
        bad++;
        $display("FAIL %s hold%0d: got v=%b r=%b %h want v=1 r=0 %h",
                 tag, i, out_valid, in_ready, observed(), exp_res);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL %s release: got v=%b r=%b want v=0 r=1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_in = 8'h00;
    b_in = 8'h00;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, observed()} !== {1'b1, 1'b0, 29'h0}) begin
      bad++;
      $display("FAIL reset_state: got r=%b v=%b %h want r=1 v=0 0", in_ready, out_valid, observed());
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(8'd100, 8'd3, 0, "a100_b3");
    run_op(8'h80, 8'd1, 0, "am128_b1");
    run_op(8'd5, 8'h80, 0, "a5_bm128");
    run_op(8'hF9, 8'd0, 0, "am7_b0");
    run_op(8'h7F, 8'h7F, 0, "a127_b127");
  endtask

  task automatic test_backpressure();
    run_op(8'd20, 8'hF4, 5, "bp_a20_bm12");
  endtask

  task automatic test_back_to_back();
    run_op(8'd1, 8'd64, 0, "b2b_0");
    run_op(8'hFF, 8'hFF, 0, "b2b_1");
    run_op(8'd77, 8'hC3, 1, "b2b_2");
  endtask

  task automatic test_out_ready_early();
    logic [28:0] exp_res;
    int exp_lat;
    int cnt;
    model(8'd50, 8'd6, exp_res, exp_lat);
    out_ready = 1'b1;
    in_valid = 1'b1;
    a_in = 8'd50;
    b_in = 8'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    total++;
    if (cnt !== exp_lat || observed() !== exp_res) begin
      bad++;
      $display("FAIL early_ready: got lat=%0d %h want lat=%0d %h", cnt, observed(), exp_lat, exp_res);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL early_ready_release: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_in_valid_held();
    logic [28:0] exp_res;
    int exp_lat;
    int cnt;
    model(8'd33, 8'hFB, exp_res, exp_lat);
    in_valid = 1'b1;
    a_in = 8'd33;
    b_in = 8'hFB;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({out_valid, in_ready} !== 2'b10) begin
        bad++;
        $display("FAIL held_done%0d: got v=%b r=%b want v=1 r=0", i, out_valid, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL held_idle: got r=%b want 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    total++;
    if (cnt !== exp_lat || observed() !== exp_res) begin
      bad++;
      $display("FAIL held_reissue: got lat=%0d %h want lat=%0d %h", cnt, observed(), exp_lat, exp_res);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_norm();
    in_valid = 1'b1;
    a_in = 8'd50;
    b_in = 8'd1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, observed()} !== {1'b1, 1'b0, 29'h0}) begin
      bad++;
      $display("FAIL mid_reset: got r=%b v=%b %h want r=1 v=0 0", in_ready, out_valid, observed());
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_no_valid%0d: got %b want 0", i, out_valid);
      end
      @(posedge clk);
      @(negedge clk);
    end
    run_op(8'd9, 8'd2, 0, "after_reset_a9_b2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_out_ready_early();
    test_in_valid_held();
    test_reset_mid_norm();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
